// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states and baud math for uart_word_tx (optional UART_WORD_TX_PARITY_EN)
package uart_pkg;

  // Transmit FSM states; PARITY exists only when the parity bit is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_state_t;

  // Clocks per serial bit, rounded to nearest.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter emitting one bit_tick per DIV clocks
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 while a word is in flight; restart aligns bit 0 to the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word-wide UART transmitter, little-endian chars, optional UART_WORD_TX_PARITY_EN
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50250000,
  parameter int BAUD       = 115200,
  parameter int WORD_WIDTH = 32,
  parameter int CHAR_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_val_i,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  data_rdy_o,
  output logic                  tx,
  output logic                  busy_o
);

  localparam int DIV   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CHARS = WORD_WIDTH / CHAR_WIDTH;
  localparam int BW    = $clog2(CHAR_WIDTH + 2);
  localparam int CCW   = $clog2(CHARS + 1);

  localparam logic [BW-1:0]  LAST_DATA = BW'(CHAR_WIDTH - 1);
  localparam logic [BW-1:0]  LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [CCW-1:0] LAST_CHAR = CCW'(CHARS - 1);

  if (WORD_WIDTH % CHAR_WIDTH != 0) begin : g_bad_word_width
    $error("uart_word_tx: WORD_WIDTH must be a multiple of CHAR_WIDTH");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_word_tx: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_word_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t           state, state_n;
  logic [WORD_WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [CCW-1:0]        char_cnt, char_cnt_n;
  logic                  tx_n;
  logic                  accept;
  logic                  bit_tick;
`ifdef UART_WORD_TX_PARITY_EN
  logic                  par, par_n;
`endif

  assign data_rdy_o = (state == IDLE);
  assign busy_o     = !data_rdy_o;
  assign accept     = data_val_i && data_rdy_o;

  uart_baud_gen #(
    .DIV(DIV)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept),
    .run      (busy_o),
    .bit_tick (bit_tick)
  );

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      char_cnt <= '0;
      tx       <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      char_cnt <= char_cnt_n;
      tx       <= tx_n;
`ifdef UART_WORD_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

  // Next-state and next-line logic; tx_n is the level for the bit that starts next cycle.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    char_cnt_n = char_cnt;
    tx_n       = tx;
`ifdef UART_WORD_TX_PARITY_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n    = START;
          shreg_n    = data_in;
          bit_cnt_n  = '0;
          char_cnt_n = '0;
          tx_n       = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
          par_n      = 1'b0;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
`ifdef UART_WORD_TX_PARITY_EN
          par_n     = 1'b0;
`endif
        end
      end
      DATA: begin
        if (bit_tick) begin
          // The character leaves LSB first; shifting also lines up the next character.
          shreg_n = shreg >> 1;
`ifdef UART_WORD_TX_PARITY_EN
          par_n   = par ^ shreg[0];
`endif
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
`ifdef UART_WORD_TX_PARITY_EN
            state_n   = PARITY;
            tx_n      = par ^ shreg[0];
`else
            state_n   = STOP;
            tx_n      = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            tx_n      = shreg[1 % WORD_WIDTH];
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n   = STOP;
          bit_cnt_n = '0;
          tx_n      = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            if (char_cnt == LAST_CHAR) begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end else begin
              // Next character starts with no idle gap.
              state_n    = START;
              char_cnt_n = char_cnt + 1'b1;
              tx_n       = 1'b0;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed table-driven bench for uart_word_tx (honours UART_WORD_TX_PARITY_EN)
module tb_uart_word_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIVB   = 10;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val_a = 1'b0;
  logic [31:0] din_a = '0;
  logic        rdy_a, tx_a, busy_a;
  logic        val_b = 1'b0;
  logic [15:0] din_b = '0;
  logic        rdy_b, tx_b, busy_b;

  always #5 clk = ~clk;

  uart_word_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_val_i(val_a), .data_in(din_a),
    .data_rdy_o(rdy_a), .tx(tx_a), .busy_o(busy_a)
  );

  uart_word_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WORD_WIDTH(16), .CHAR_WIDTH(8), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_val_i(val_b), .data_in(din_b),
    .data_rdy_o(rdy_b), .tx(tx_b), .busy_o(busy_b)
  );

  typedef struct {
    logic [31:0]       word;
    logic [3:0][7:0]   ch;
    int                nch;
    int                sb;
    int                dur;
    bit                sel;
    bit                pre;
    bit                hold;
    int                inject;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic cur_rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic drive(input bit sel, input logic val, input logic [31:0] w);
    if (sel) begin
      val_b = val;
      din_b = w[15:0];
    end else begin
      val_a = val;
      din_a = w;
    end
  endtask

  // Offers v.word (unless already offered), then checks every cycle of the frame.
  task automatic run_word(input vec_t v, input logic [31:0] next_w, input string tag);
    logic frame[64];
    int   nb;
    int   waited;
    bit   ok;
    bit   rdy_ok;
    logic bad;
    nb = 0;
    for (int c = 0; c < v.nch; c++) begin
      frame[nb] = 1'b0;
      nb++;
      for (int b = 0; b < 8; b++) begin
        frame[nb] = v.ch[c][b];
        nb++;
      end
      if (P == 1) begin
        frame[nb] = ^v.ch[c];
        nb++;
      end
      for (int s = 0; s < v.sb; s++) begin
        frame[nb] = 1'b1;
        nb++;
      end
    end
    if (!v.pre) begin
      waited = 0;
      while (cur_rdy(v.sel) !== 1'b1 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("%s rdy_wait", tag), 32'(waited < 50), 32'd1);
      drive(v.sel, 1'b1, v.word);
    end
    @(posedge clk);
    ok = 1'b1;
    rdy_ok = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= v.dur; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (v.hold) drive(v.sel, 1'b1, next_w);
        else drive(v.sel, 1'b0, ~v.word);
      end
      if (v.inject != 0 && k == v.inject) drive(v.sel, 1'b1, 32'hDEADBEEF);
      if (v.inject != 0 && k == v.inject + 1) drive(v.sel, 1'b0, ~v.word);
      if (cur_tx(v.sel) !== frame[(k - 1) / DIVB]) begin
        ok = 1'b0;
        bad = cur_tx(v.sel);
      end
      if (cur_rdy(v.sel) !== 1'b0 || cur_busy(v.sel) !== 1'b1) rdy_ok = 1'b0;
      if (k % DIVB == 0) begin
        check($sformatf("%s bit%0d", tag, (k - 1) / DIVB),
              32'(ok ? frame[(k - 1) / DIVB] : bad), 32'(frame[(k - 1) / DIVB]));
        ok = 1'b1;
      end
    end
    check($sformatf("%s rdy_low_whole_word", tag), 32'(rdy_ok), 32'd1);
    @(negedge clk);
    check($sformatf("%s rdy_after", tag), 32'(cur_rdy(v.sel)), 32'd1);
    check($sformatf("%s busy_after", tag), 32'(cur_busy(v.sel)), 32'd0);
    check($sformatf("%s tx_idle_after", tag), 32'(cur_tx(v.sel)), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11}, 4, 1, (P ? 440 : 400), 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{32'h000000FF, {8'h00, 8'h00, 8'h00, 8'hFF}, 4, 1, (P ? 440 : 400), 1'b0, 1'b0, 1'b1, 0};
    vecs[2] = '{32'h80030107, {8'h80, 8'h03, 8'h01, 8'h07}, 4, 1, (P ? 440 : 400), 1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{32'h12345678, {8'h12, 8'h34, 8'h56, 8'h78}, 4, 1, (P ? 440 : 400), 1'b0, 1'b0, 1'b0, 100};
    vecs[4] = '{32'h0000A55A, {8'h00, 8'h00, 8'hA5, 8'h5A}, 2, 2, (P ? 240 : 220), 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{32'h000000A5, {8'h00, 8'h00, 8'h00, 8'hA5}, 4, 1, (P ? 440 : 400), 1'b0, 1'b1, 1'b0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_a", 32'(tx_a), 32'd1);
    check("reset rdy_a", 32'(rdy_a), 32'd1);
    check("reset busy_a", 32'(busy_a), 32'd0);
    check("reset tx_b", 32'(tx_b), 32'd1);
    check("reset rdy_b", 32'(rdy_b), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i], (i < 4) ? vecs[i + 1].word : 32'h0, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a word (tx low at clock 150).
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h44332211);
    @(posedge clk);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 32'h0);
    end
    check("midreset tx_before", 32'(tx_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midreset tx_async", 32'(tx_a), 32'd1);
    check("midreset rdy_async", 32'(rdy_a), 32'd1);
    check("midreset busy_async", 32'(busy_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midreset tx_held", 32'(tx_a), 32'd1);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, vecs[5].word);
    run_word(vecs[5], 32'h0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
